ysyx_22040386_lsu: RTL and testbench

- Load/store unit between the EXU result stage and the data-memory bus. Consumes the decoder's MemWrite, Mem_to_Reg and Wmask controls, plus funct3 and the ALU-computed address.
- Runs one memory transaction at a time over a req/ready + rvalid bus.
- Returns a sign- or zero-extended load value, or a store completion, with an error flag.

---
 rtl/ysyx_22040386_lsu.sv | 172 +++++++++++++++++
 tb/tb_ysyx_22040386_lsu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040386_lsu.sv
// Load/store unit: one transaction at a time over a req/ready + rvalid data bus,
// returning an extended load value or store completion with an error flag.
module ysyx_22040386_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic        in_memwrite,
  input  logic        in_memread,
  input  logic [2:0]  in_funct3,
  input  logic [7:0]  in_wmask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic        out_err,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_n;
  logic [63:0]      addr_q, wdata_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [7:0]       wmask_q;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [63:0]      rdata_q, rdata_n;
  logic             err_q, err_n;
  logic             accept, misaligned, bad_req, timeout_hit;
  logic [63:0]      shifted, load_val;

  assign in_ready = (state == IDLE) && rst_n;
  assign accept   = in_valid && in_ready;

  always_comb begin
    misaligned = 1'b0;
    case (in_funct3[1:0])
      2'd0: misaligned = 1'b0;
      2'd1: misaligned = in_addr[0];
      2'd2: misaligned = |in_addr[1:0];
      2'd3: misaligned = |in_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign bad_req = (in_memwrite && in_memread) ||
                   (in_memread && (in_funct3 == 3'b111)) ||
                   misaligned;

  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (cnt_inc == TMO);

  assign shifted = mem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_val = '0;
    case (f3_q)
      3'b000: load_val = {{56{shifted[7]}},  shifted[7:0]};
      3'b001: load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010: load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b011: load_val = shifted;
      3'b100: load_val = {56'd0, shifted[7:0]};
      3'b101: load_val = {48'd0, shifted[15:0]};
      3'b110: load_val = {32'd0, shifted[31:0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rdata_n = rdata_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (accept) begin
          rdata_n = '0;
          err_n   = 1'b0;
          cnt_n   = '0;
          if (!in_memwrite && !in_memread) begin
            state_n = DONE;
          end else if (bad_req) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        cnt_n = cnt_inc;
        if (timeout_hit) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else if (mem_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt_inc;
        // a response on the final budget cycle still counts as completion
        if (mem_rvalid) begin
          state_n = DONE;
          rdata_n = we_q ? '0 : load_val;
          err_n   = 1'b0;
        end else if (timeout_hit) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
          rdata_n = '0;
          err_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      wmask_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
      if (accept) begin
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        we_q    <= in_memwrite;
        f3_q    <= in_funct3;
        wmask_q <= in_wmask;
      end
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? {addr_q[63:3], 3'b000} : '0;
  assign mem_wdata = mem_we ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
  assign mem_wstrb = mem_we ? (wmask_q << addr_q[2:0]) : '0;

  assign out_valid = (state == DONE);
  assign out_rdata = out_valid ? rdata_q : '0;
  assign out_err   = out_valid && err_q;

endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// Randomized bench for the LSU: a bus responder with programmable delays and a
// reference model of alignment, legality, extraction and the timeout budget.
module tb_ysyx_22040386_lsu;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_addr, in_wdata;
  logic        in_memwrite, in_memread;
  logic [2:0]  in_funct3;
  logic [7:0]  in_wmask;
  logic        out_valid, out_ready;
  logic [63:0] out_rdata;
  logic        out_err;
  logic        mem_req, mem_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ysyx_22040386_lsu #(.TIMEOUT_CYCLES(TMO), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_memwrite(in_memwrite), .in_memread(in_memread), .in_funct3(in_funct3),
    .in_wmask(in_wmask),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] word, input int off,
                                           input logic [2:0] f3);
    int          nbytes;
    logic [63:0] keep, v;
    nbytes = 1 << f3[1:0];
    keep   = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    v      = (word >> (8 * off)) & keep;
    if (!f3[2] && v[8 * nbytes - 1]) v = v | ~keep;
    return v;
  endfunction

  function automatic logic [7:0] size_mask(input logic [2:0] f3);
    int nbytes;
    nbytes = 1 << f3[1:0];
    return 8'((16'd1 << nbytes) - 16'd1);
  endfunction

  // Called and returns on a falling edge with the LSU idle.
  task automatic run_txn(input logic [63:0] addr, input logic [63:0] wdata,
                         input logic we, input logic re, input logic [2:0] f3,
                         input logic [7:0] wmask, input int ready_dly, input int valid_dly,
                         input logic ghost, input logic [63:0] rword, input int stall);
    int          off, nbytes, k;
    logic        bus, exp_err, granted, fin;
    logic [63:0] exp_data;
    off      = int'(addr[2:0]);
    nbytes   = 1 << f3[1:0];
    bus      = 1'b0;
    exp_err  = 1'b0;
    exp_data = '0;
    if (!we && !re) exp_err = 1'b0;
    else if (we && re) exp_err = 1'b1;
    else if (re && f3 == 3'b111) exp_err = 1'b1;
    else if ((addr % nbytes) != 0) exp_err = 1'b1;
    else bus = 1'b1;

    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_memwrite = we;
    in_memread = re; in_funct3 = f3; in_wmask = wmask;
    @(negedge clk);
    in_valid = 1'b0; in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
    in_memwrite = 1'(~we); in_memread = 1'(~re); in_funct3 = 3'($urandom);

    if (bus) begin
      granted = 1'b0; fin = 1'b0; k = 0;
      while (!fin && k < 200) begin
        k++;
        check("mem_req", mem_req, !granted);
        check("out_valid_busy", out_valid, 0);
        if (!granted) begin
          check("mem_addr", mem_addr, addr & ~64'h7);
          check("mem_we", mem_we, we);
          check("mem_wstrb", mem_wstrb, we ? 8'(wmask << off) : 8'h00);
          if (we) check("mem_wdata", mem_wdata, wdata << (8 * off));
        end
        mem_ready  = !granted && (k > ready_dly);
        mem_rvalid = granted ? (k > ready_dly + 1 + valid_dly) : (ghost && mem_ready);
        mem_rdata  = (granted && mem_rvalid) ? rword : {$urandom, $urandom};
        if (granted && mem_rvalid) begin
          fin = 1'b1;
          exp_data = we ? 64'd0 : ref_load(rword, off, f3);
        end else if (k == TMO) begin
          fin = 1'b1;
          exp_err = 1'b1;
        end else if (mem_ready) begin
          granted = 1'b1;
        end
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b0;
      end
      if (!fin) check("txn_bound", 0, 1);
    end

    for (int i = 0; i <= stall; i++) begin
      check("out_valid", out_valid, 1);
      check("out_rdata", out_rdata, exp_data);
      check("out_err", out_err, exp_err);
      check("in_ready_done", in_ready, 0);
      check("mem_req_done", mem_req, 0);
      out_ready = (i == stall);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("out_valid_exit", out_valid, 0);
    check("out_rdata_exit", out_rdata, 0);
  endtask

  initial begin
    logic [63:0] a, wd;
    logic        we, re;
    logic [2:0]  f3;
    int          r, rd, vd;

    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_memwrite = 1'b0;
    in_memread = 1'b0; in_funct3 = '0; in_wmask = '0; out_ready = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_out_rdata", out_rdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(64'h8000_0010, 64'h0, 1'b0, 1'b1, 3'b011, 8'hFF, 0, 0, 1'b0,
            64'h1122_3344_5566_7788, 0);
    run_txn(64'h8000_0003, 64'h0, 1'b0, 1'b1, 3'b000, 8'h01, 1, 2, 1'b0,
            64'h0000_0000_8000_0000, 0);
    run_txn(64'h8000_0003, 64'h0, 1'b0, 1'b1, 3'b100, 8'h01, 0, 1, 1'b1,
            64'h0000_0000_8000_0000, 0);
    run_txn(64'h8000_0006, 64'hABCD, 1'b1, 1'b0, 3'b001, 8'h03, 2, 0, 1'b0,
            64'hDEAD_BEEF_0000_0000, 0);
    run_txn(64'h8000_0002, 64'h0, 1'b0, 1'b1, 3'b010, 8'h0F, 0, 0, 1'b0, 64'h0, 0);
    run_txn(64'h8000_0008, 64'h0, 1'b0, 1'b1, 3'b011, 8'hFF, 5, 1000, 1'b0, 64'h0, 0);
    run_txn(64'h8000_0008, 64'h0, 1'b0, 1'b1, 3'b011, 8'hFF, 100, 0, 1'b0, 64'h0, 0);
    run_txn(64'h8000_0004, 64'h0, 1'b0, 1'b1, 3'b010, 8'hFF, 2, 60, 1'b0,
            64'h8765_4321_0000_0000, 0);
    run_txn(64'h8000_0004, 64'h0, 1'b0, 1'b1, 3'b110, 8'hFF, 2, 61, 1'b0, 64'h0, 0);
    run_txn(64'h8000_0018, 64'h0, 1'b0, 1'b1, 3'b111, 8'hFF, 0, 0, 1'b0, 64'h0, 0);
    run_txn(64'h8000_0018, 64'h5, 1'b1, 1'b1, 3'b011, 8'hFF, 0, 0, 1'b0, 64'h0, 0);
    run_txn(64'h8000_0001, 64'h5, 1'b0, 1'b0, 3'b011, 8'hFF, 0, 0, 1'b0, 64'h0, 0);
    run_txn(64'h8000_0020, 64'h0, 1'b0, 1'b1, 3'b001, 8'h03, 0, 0, 1'b0,
            64'h0000_0000_0000_9ABC, 3);

    // reset while the request is on the bus
    in_valid = 1'b1; in_addr = 64'h8000_0040; in_memread = 1'b1; in_memwrite = 1'b0;
    in_funct3 = 3'b011; in_wmask = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstreq_mem_req_before", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 check("rstreq_mem_req", mem_req, 0);
    check("rstreq_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset while waiting for the response, then a late response
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rstwait_mem_req", mem_req, 0);
    check("rstwait_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1 check("rstwait_out_valid", out_valid, 0);
    check("rstwait_in_ready_rst", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h1234;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_out_valid", out_valid, 0);
    check("late_rvalid_in_ready", in_ready, 1);

    // reset while holding a result
    in_valid = 1'b1; in_memread = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstdone_out_valid_before", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check("rstdone_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 250; n++) begin
      r  = $urandom_range(0, 9);
      we = (r == 1) || (r >= 6);
      re = (r >= 1) && (r <= 5);
      f3 = we && !re ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                       : 64'h8000_0000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0)
        a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      wd = {$urandom, $urandom};
      r  = $urandom_range(0, 19);
      rd = (r == 0) ? $urandom_range(60, 70) : $urandom_range(0, 4);
      vd = (r == 1) ? $urandom_range(55, 70) : $urandom_range(0, 4);
      run_txn(a, wd, we, re, f3, size_mask(f3), rd, vd, 1'($urandom),
              {$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
